// File: rtl/recon_head_pkg.sv
// Shared fixed-point helpers for the reconstruction head: widths, FSM states,
// and the round-half-up / clamp-to-[0,1] function used by every output lane.
package hcvc_fixed_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned FRAC_BITS_DEF  = 8;
    localparam int unsigned RC_W           = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    typedef struct packed {
        logic            clamped;
        logic [RC_W-1:0] value;
    } rc_t;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cin);
        return 2 * dw + $clog2(cin) + 1;
    endfunction

    // The accumulator is widened to RC_W so one function serves any lane width.
    function automatic rc_t round_clamp(input logic signed [RC_W-1:0] acc,
                                        input int unsigned frac);
        logic signed [RC_W-1:0] one;
        logic signed [RC_W-1:0] r;
        rc_t                    res;
        one         = RC_W'(1) <<< frac;
        r           = (acc + (one >>> 1)) >>> frac;
        res.clamped = 1'b0;
        res.value   = RC_W'(r);
        if (r < 0) begin
            res.clamped = 1'b1;
            res.value   = '0;
        end else if (r > one) begin
            res.clamped = 1'b1;
            res.value   = RC_W'(one);
        end
        return res;
    endfunction

endpackage

// File: rtl/recon_head_if.sv
// Pixel stream bundle: decoder-side input handshake and consumer-side output handshake.
interface recon_head_if
    import hcvc_fixed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned CHANNEL_IN  = 32,
    parameter int unsigned CHANNEL_OUT = 3
);
    logic                              in_valid;
    logic                              in_ready;
    logic [CHANNEL_IN*DATA_WIDTH-1:0]  in_data;
    logic                              in_last;
    logic                              out_valid;
    logic                              out_ready;
    logic [CHANNEL_OUT*DATA_WIDTH-1:0] out_data;
    logic                              out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/recon_head_mac_lane.sv
// One output channel: bias preload, serial multiply-accumulate, and registered
// round/clamp result.
module mac_lane
    import hcvc_fixed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
    parameter int unsigned ACC_W      = 38
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  logic                         i_acc_en,
    input  logic                         i_round,
    input  logic signed [DATA_WIDTH-1:0] i_bias,
    input  logic signed [DATA_WIDTH-1:0] i_x,
    input  logic signed [DATA_WIDTH-1:0] i_w,
    output logic        [DATA_WIDTH-1:0] o_y,
    output logic                         o_clamped_c
);
    logic signed [ACC_W-1:0]        r_acc;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    rc_t                            w_rc;
    logic                           w_unused_bits;

    assign w_prod        = i_x * i_w;
    assign w_rc          = round_clamp(RC_W'(r_acc), FRAC_BITS);
    assign o_clamped_c   = w_rc.clamped;
    assign w_unused_bits = ^w_rc.value[RC_W-1:DATA_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            o_y   <= '0;
        end else begin
            if (i_load) begin
                r_acc <= ACC_W'(i_bias) <<< FRAC_BITS;
            end else if (i_acc_en) begin
                r_acc <= r_acc + ACC_W'(w_prod);
            end
            if (i_round) begin
                o_y <= DATA_WIDTH'(w_rc.value);
            end
        end
    end
endmodule

// File: rtl/recon_head.sv
// Streaming 1x1 reconstruction head: serial-over-input-channel MAC producing a
// clamped CHANNEL_OUT-channel pixel per accepted feature pixel.
module recon_head
    import hcvc_fixed_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned FRAC_BITS   = FRAC_BITS_DEF,
    parameter int unsigned CHANNEL_IN  = 32,
    parameter int unsigned CHANNEL_OUT = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [CHANNEL_OUT*CHANNEL_IN*DATA_WIDTH-1:0] weights,
    input  logic [CHANNEL_OUT*DATA_WIDTH-1:0]            bias,
    recon_head_if.slave                                  bus,
    output logic                                         frame_done,
    output logic                                         busy,
    output logic [15:0]                                  sat_count
);
    localparam int unsigned ACC_W = acc_width(DATA_WIDTH, CHANNEL_IN);
    localparam int unsigned CNT_W = (CHANNEL_IN > 1) ? $clog2(CHANNEL_IN) : 1;
    localparam int unsigned CLW   = $clog2(CHANNEL_OUT + 1);

    state_t                            r_state, w_state_nxt;
    logic [CNT_W-1:0]                  r_cnt, w_cnt_nxt;
    logic [CHANNEL_IN*DATA_WIDTH-1:0]  r_x;
    logic                              r_last;
    logic                              w_load, w_acc_en, w_round, w_frame_done_nxt;
    logic [CHANNEL_OUT-1:0]            w_clamped;
    logic [CLW-1:0]                    w_nclamp;
    logic [16:0]                       w_sat_sum;
    logic [15:0]                       w_sat_nxt;
    logic [DATA_WIDTH-1:0]             w_xs [CHANNEL_IN];
    logic [DATA_WIDTH-1:0]             w_x_sel;
    logic [CHANNEL_OUT*DATA_WIDTH-1:0] w_y;

    for (genvar c = 0; c < CHANNEL_IN; c++) begin : g_xs
        assign w_xs[c] = r_x[c*DATA_WIDTH +: DATA_WIDTH];
    end
    assign w_x_sel = w_xs[r_cnt];

    for (genvar o = 0; o < CHANNEL_OUT; o++) begin : g_lane
        logic [DATA_WIDTH-1:0] w_ws [CHANNEL_IN];
        for (genvar c = 0; c < CHANNEL_IN; c++) begin : g_ws
            assign w_ws[c] = weights[(o*CHANNEL_IN+c)*DATA_WIDTH +: DATA_WIDTH];
        end
        mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .ACC_W      (ACC_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_load      (w_load),
            .i_acc_en    (w_acc_en),
            .i_round     (w_round),
            .i_bias      (bias[o*DATA_WIDTH +: DATA_WIDTH]),
            .i_x         (w_x_sel),
            .i_w         (w_ws[r_cnt]),
            .o_y         (w_y[o*DATA_WIDTH +: DATA_WIDTH]),
            .o_clamped_c (w_clamped[o])
        );
    end
    assign bus.out_data = w_y;

    // Saturating count of channels clamped in the current ROUND cycle.
    always_comb begin
        w_nclamp = '0;
        for (int unsigned i = 0; i < CHANNEL_OUT; i++) begin
            w_nclamp = w_nclamp + CLW'(w_clamped[i]);
        end
        w_sat_sum = {1'b0, sat_count} + 17'(w_nclamp);
        w_sat_nxt = w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_load           = 1'b0;
        w_acc_en         = 1'b0;
        w_round          = 1'b0;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                w_acc_en  = 1'b1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(CHANNEL_IN - 1)) begin
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_round     = 1'b1;
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    w_frame_done_nxt = bus.out_last;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_x           <= '0;
            r_last        <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
            sat_count     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            bus.in_ready  <= (w_state_nxt == ST_IDLE);
            bus.out_valid <= (w_state_nxt == ST_OUT);
            busy          <= (w_state_nxt != ST_IDLE);
            frame_done    <= w_frame_done_nxt;
            if (w_load) begin
                r_x    <= bus.in_data;
                r_last <= bus.in_last;
            end
            if (w_round) begin
                bus.out_last <= r_last;
                sat_count    <= w_sat_nxt;
            end
        end
    end
endmodule

// File: tb/tb_recon_head.sv
// Directed bench for recon_head with CHANNEL_IN=4, CHANNEL_OUT=3 and
// hand-computed expected pixels.
module tb_recon_head;
    localparam int unsigned DW   = 16;
    localparam int unsigned CIN  = 4;
    localparam int unsigned COUT = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [COUT*CIN*DW-1:0] weights;
    logic [COUT*DW-1:0]     bias;
    logic                   frame_done;
    logic                   busy;
    logic [15:0]            sat_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    recon_head_if #(.DATA_WIDTH(DW), .CHANNEL_IN(CIN), .CHANNEL_OUT(COUT)) bus ();

    recon_head #(
        .DATA_WIDTH  (DW),
        .FRAC_BITS   (8),
        .CHANNEL_IN  (CIN),
        .CHANNEL_OUT (COUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .weights    (weights),
        .bias       (bias),
        .bus        (bus.slave),
        .frame_done (frame_done),
        .busy       (busy),
        .sat_count  (sat_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_uniform(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
        for (int i = 0; i < int'(CIN); i++) bus.in_data[i*DW +: DW] = x;
        for (int i = 0; i < int'(COUT*CIN); i++) weights[i*DW +: DW] = w;
        for (int i = 0; i < int'(COUT); i++) bias[i*DW +: DW] = b;
    endtask

    task automatic accept(input string tag, input logic last);
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_in_ready_low"}, 64'(bus.in_ready), 64'd0);
    endtask

    // Accept edge T; MAC edges T+1..T+4; out_valid rises after ROUND edge T+5.
    task automatic run_pixel(input string tag, input logic [15:0] x, input logic [15:0] w,
                             input logic [15:0] b, input logic [15:0] y, input logic [15:0] sat);
        set_uniform(x, w, b);
        accept(tag, 1'b0);
        repeat (CIN) tick();
        check({tag, "_valid_early"}, 64'(bus.out_valid), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_data"}, 64'(bus.out_data), 64'({y, y, y}));
        check({tag, "_sat"}, 64'(sat_count), 64'(sat));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_no_frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        rst           = 1'b0;
        weights       = '0;
        bias          = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sat", 64'(sat_count), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        run_pixel("nominal", 16'h0100, 16'h0040, 16'h0000, 16'h0100, 16'd0);
        run_pixel("neg_clamp", 16'h0100, 16'hFF00, 16'h0000, 16'h0000, 16'd3);
        run_pixel("pos_clamp", 16'h0000, 16'h0000, 16'h0200, 16'h0100, 16'd6);
        run_pixel("round", 16'h0001, 16'h0060, 16'h0000, 16'h0002, 16'd6);

        // Backpressure on the frame's last pixel.
        set_uniform(16'h0100, 16'h0040, 16'h0000);
        accept("bp", 1'b1);
        repeat (CIN + 1) tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_data", 64'(bus.out_data), 64'h0100_0100_0100);
            check("bp_last", 64'(bus.out_last), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_frame_done_early", 64'(frame_done), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_frame_done", 64'(frame_done), 64'd1);
        check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
        check("bp_valid_drop", 64'(bus.out_valid), 64'd0);
        tick();
        check("bp_frame_done_1cyc", 64'(frame_done), 64'd0);
        check("bp_in_ready_next", 64'(bus.in_ready), 64'd1);

        // Reset asserted during MAC cycle 2 aborts the pixel.
        set_uniform(16'h0100, 16'h0040, 16'h0000);
        accept("abort", 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("abort_busy_in_rst", 64'(busy), 64'd0);
        check("abort_valid_in_rst", 64'(bus.out_valid), 64'd0);
        check("abort_sat_in_rst", 64'(sat_count), 64'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_no_valid", 64'(bus.out_valid), 64'd0);
        end
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_sat", 64'(sat_count), 64'd0);
        check("abort_out_data", 64'(bus.out_data), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
